// File: rtl/fifo_pkg.sv
// Shared types and default constants for the FIFO controller.
package fifo_pkg;

    localparam int unsigned ADDR_WIDTH_DEF       = 8;
    localparam int unsigned DATA_WIDTH_DEF       = 8;
    localparam int unsigned DEPTH                = 1 << ADDR_WIDTH_DEF;
    localparam int unsigned ALMOST_FULL_LVL_DEF  = DEPTH - 4;
    localparam int unsigned ALMOST_EMPTY_LVL_DEF = 4;

    // Wrap-bit pointer: low bits address the RAM, MSB toggles every pass.
    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;
    // Occupancy count, 0..DEPTH inclusive.
    typedef logic [ADDR_WIDTH_DEF:0] count_t;

endpackage

// File: rtl/fifo_ptr.sv
// Enable-gated wrap-bit pointer with synchronous active-low reset.
module fifo_ptr #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    // Advance by one per enabled cycle, wrapping modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving a dual-port RAM (port 0 write, port 1 read).
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int unsigned ALMOST_FULL_LVL  = (1 << ADDR_WIDTH) - 4,
    parameter int unsigned ALMOST_EMPTY_LVL = ALMOST_EMPTY_LVL_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] ram_address_0,
    output logic                  ram_chip_enable_0,
    output logic                  ram_write_read_0,
    output logic [DATA_WIDTH-1:0] ram_data_0,
    output logic [ADDR_WIDTH-1:0] ram_address_1,
    output logic                  ram_chip_enable_1,
    output logic                  ram_write_read_1,
    input  logic [DATA_WIDTH-1:0] ram_data_1
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_acc;
    logic          pop_acc;

    // Request acceptance; nothing is accepted while reset is asserted.
    always_comb begin
        push_acc = rst_n && push && !full;
        pop_acc  = rst_n && pop  && !empty;
    end

    fifo_ptr #(.WIDTH(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (push_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.WIDTH(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pop_acc),
        .ptr   (rd_ptr)
    );

    // Occupancy flags decoded from the registered pointers and count.
    always_comb begin
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                       (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        almost_full  = (count >= PW'(ALMOST_FULL_LVL));
        almost_empty = (count <= PW'(ALMOST_EMPTY_LVL));
    end

    // RAM port drive: port 0 writes accepted pushes, port 1 reads accepted pops.
    always_comb begin
        ram_address_0     = wr_ptr[ADDR_WIDTH-1:0];
        ram_chip_enable_0 = push_acc;
        ram_write_read_0  = push_acc;
        ram_data_0        = push_data;
        ram_address_1     = rd_ptr[ADDR_WIDTH-1:0];
        ram_chip_enable_1 = pop_acc;
        ram_write_read_1  = 1'b0;
    end

    // Occupancy count tracks wr_ptr - rd_ptr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push_acc, pop_acc})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

    // One-cycle read stage; pop_data holds when no pop is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= pop_acc;
            if (pop_acc) begin
                pop_data <= ram_data_1;
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags for requests made against a full or empty FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl (ADDR_WIDTH=2, DEPTH=4).
// Checks the sticky error flags too when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic [AW-1:0] ram_address_0;
    logic          ram_chip_enable_0;
    logic          ram_write_read_0;
    logic [DW-1:0] ram_data_0;
    logic [AW-1:0] ram_address_1;
    logic          ram_chip_enable_1;
    logic          ram_write_read_1;
    logic [DW-1:0] ram_data_1;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [4];
    logic [DW-1:0] exp_q [$];

    fifo_ctrl #(
        .DATA_WIDTH       (DW),
        .ADDR_WIDTH       (AW),
        .ALMOST_FULL_LVL  (3),
        .ALMOST_EMPTY_LVL (1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .push              (push),
        .push_data         (push_data),
        .pop               (pop),
        .pop_data          (pop_data),
        .pop_valid         (pop_valid),
        .full              (full),
        .empty             (empty),
        .almost_full       (almost_full),
        .almost_empty      (almost_empty),
        .count             (count),
        .ram_address_0     (ram_address_0),
        .ram_chip_enable_0 (ram_chip_enable_0),
        .ram_write_read_0  (ram_write_read_0),
        .ram_data_0        (ram_data_0),
        .ram_address_1     (ram_address_1),
        .ram_chip_enable_1 (ram_chip_enable_1),
        .ram_write_read_1  (ram_write_read_1),
        .ram_data_1        (ram_data_1)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow          (overflow),
        .underflow         (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port RAM: synchronous write, combinational read, cleared on reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else if (ram_chip_enable_0 && ram_write_read_0) begin
            mem[ram_address_0] <= ram_data_0;
        end
    end
    assign ram_data_1 = mem[ram_address_1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push = 1'b1; pop = 1'b1; push_data = 8'hEE;
        #1;
        checks++;
        if (ram_chip_enable_0 !== 1'b0 || ram_chip_enable_1 !== 1'b0 || ram_write_read_0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_enables: ce0=%b we0=%b ce1=%b required 0 0 0",
                     ram_chip_enable_0, ram_write_read_0, ram_chip_enable_1);
        end
        step(); step();
        push = 1'b0; pop = 1'b0; rst_n = 1'b1;
        step();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0 || pop_valid !== 1'b0 || pop_data !== 8'h00 ||
            almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: empty=%b full=%b count=%0d pv=%b pd=%h ae=%b af=%b required 1 0 0 0 00 1 0",
                     empty, full, count, pop_valid, pop_data, almost_empty, almost_full);
        end
        checks++;
        if (ram_chip_enable_0 !== 1'b0 || ram_chip_enable_1 !== 1'b0 || ram_write_read_1 !== 1'b0) begin
            failures++;
            $display("FAIL idle_enables: ce0=%b ce1=%b we1=%b required 0 0 0",
                     ram_chip_enable_0, ram_chip_enable_1, ram_write_read_1);
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: ovf=%b unf=%b required 0 0", overflow, underflow);
        end
`endif
    endtask

    task automatic test_fill();
        logic [DW-1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = DW'((i + 1) * 'h11);
            push = 1'b1; push_data = d;
            #1;
            checks++;
            if (ram_address_0 !== AW'(i) || ram_chip_enable_0 !== 1'b1 || ram_write_read_0 !== 1'b1 ||
                ram_data_0 !== d) begin
                failures++;
                $display("FAIL fill_write[%0d]: addr=%0d ce0=%b we0=%b data=%h required %0d 1 1 %h",
                         i, ram_address_0, ram_chip_enable_0, ram_write_read_0, ram_data_0, i, d);
            end
            exp_q.push_back(d);
            step();
            push = 1'b0;
            checks++;
            if (count !== 3'(i + 1) || empty !== 1'b0 || full !== (i == 3) ||
                almost_full !== (i >= 2) || almost_empty !== (i == 0)) begin
                failures++;
                $display("FAIL fill_flags[%0d]: count=%0d empty=%b full=%b af=%b ae=%b required %0d 0 %b %b %b",
                         i, count, empty, full, almost_full, almost_empty, i + 1, i == 3, i >= 2, i == 0);
            end
        end
    endtask

    task automatic test_overflow();
        push = 1'b1; pop = 1'b0; push_data = 8'h55;
        #1;
        checks++;
        if (ram_chip_enable_0 !== 1'b0 || ram_write_read_0 !== 1'b0) begin
            failures++;
            $display("FAIL overflow_nowrite: ce0=%b we0=%b required 0 0", ram_chip_enable_0, ram_write_read_0);
        end
        step();
        push = 1'b0;
        checks++;
        if (count !== 3'd4 || full !== 1'b1) begin
            failures++;
            $display("FAIL overflow_count: count=%0d full=%b required 4 1", count, full);
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b1 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_flag: ovf=%b unf=%b required 1 0", overflow, underflow);
        end
`endif
    endtask

    task automatic test_drain();
        logic [DW-1:0] e;
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            #1;
            checks++;
            if (ram_chip_enable_1 !== 1'b1 || ram_address_1 !== AW'(i)) begin
                failures++;
                $display("FAIL drain_read[%0d]: ce1=%b addr=%0d required 1 %0d", i, ram_chip_enable_1, ram_address_1, i);
            end
            e = exp_q.pop_front();
            step();
            pop = 1'b0;
            checks++;
            if (pop_valid !== 1'b1 || pop_data !== e || count !== 3'(3 - i) || empty !== (i == 3)) begin
                failures++;
                $display("FAIL drain_data[%0d]: pv=%b pd=%h count=%0d empty=%b required 1 %h %0d %b",
                         i, pop_valid, pop_data, count, empty, e, 3 - i, i == 3);
            end
        end
        step();
        checks++;
        if (pop_valid !== 1'b0 || pop_data !== 8'h44) begin
            failures++;
            $display("FAIL drain_hold: pv=%b pd=%h required 0 44", pop_valid, pop_data);
        end
        pop = 1'b1;
        #1;
        checks++;
        if (ram_chip_enable_1 !== 1'b0) begin
            failures++;
            $display("FAIL underflow_noread: ce1=%b required 0", ram_chip_enable_1);
        end
        step();
        pop = 1'b0;
        checks++;
        if (pop_valid !== 1'b0 || empty !== 1'b1 || count !== 3'd0) begin
            failures++;
            $display("FAIL underflow_state: pv=%b empty=%b count=%0d required 0 1 0", pop_valid, empty, count);
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_flag: unf=%b required 1", underflow);
        end
`endif
    endtask

    task automatic test_empty_push_pop();
        push = 1'b1; pop = 1'b1; push_data = 8'h01;
        #1;
        checks++;
        if (ram_chip_enable_0 !== 1'b1 || ram_chip_enable_1 !== 1'b0 || ram_address_0 !== 2'd0) begin
            failures++;
            $display("FAIL empty_pushpop: ce0=%b ce1=%b addr0=%0d required 1 0 0",
                     ram_chip_enable_0, ram_chip_enable_1, ram_address_0);
        end
        exp_q.push_back(8'h01);
        step();
        pop = 1'b0; push_data = 8'h02;
        exp_q.push_back(8'h02);
        step();
        push = 1'b0;
        checks++;
        if (count !== 3'd2 || pop_valid !== 1'b0 || almost_empty !== 1'b0 || almost_full !== 1'b0) begin
            failures++;
            $display("FAIL preload: count=%0d pv=%b ae=%b af=%b required 2 0 0 0",
                     count, pop_valid, almost_empty, almost_full);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        logic [AW-1:0] a;
        for (int i = 0; i < 6; i++) begin
            push = 1'b1; pop = 1'b1; push_data = DW'('hA0 + i);
            a = AW'(2 + i);
            #1;
            checks++;
            if (ram_address_0 !== a || ram_chip_enable_0 !== 1'b1 || ram_chip_enable_1 !== 1'b1 ||
                ram_address_1 !== AW'(i)) begin
                failures++;
                $display("FAIL wrap_ports[%0d]: a0=%0d ce0=%b ce1=%b a1=%0d required %0d 1 1 %0d",
                         i, ram_address_0, ram_chip_enable_0, ram_chip_enable_1, ram_address_1, a, AW'(i));
            end
            exp_q.push_back(push_data);
            e = exp_q.pop_front();
            step();
            checks++;
            if (pop_valid !== 1'b1 || pop_data !== e || count !== 3'd2) begin
                failures++;
                $display("FAIL wrap_data[%0d]: pv=%b pd=%h count=%0d required 1 %h 2",
                         i, pop_valid, pop_data, count, e);
            end
        end
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset_mid();
        push = 1'b1; push_data = 8'hC3;
        step();
        push = 1'b0;
        checks++;
        if (count !== 3'd3 || almost_full !== 1'b1) begin
            failures++;
            $display("FAIL mid_precount: count=%0d af=%b required 3 1", count, almost_full);
        end
        rst_n = 1'b0; push = 1'b1; pop = 1'b1; push_data = 8'h77;
        step();
        rst_n = 1'b1; push = 1'b0; pop = 1'b0;
        exp_q.delete();
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || pop_valid !== 1'b0 || pop_data !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset: count=%0d empty=%b full=%b pv=%b pd=%h required 0 1 0 0 00",
                     count, empty, full, pop_valid, pop_data);
        end
        push = 1'b1; push_data = 8'h9A;
        step();
        push = 1'b0; pop = 1'b1;
        #1;
        checks++;
        if (ram_address_1 !== 2'd0 || ram_chip_enable_1 !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_read: a1=%0d ce1=%b required 0 1", ram_address_1, ram_chip_enable_1);
        end
        step();
        pop = 1'b0;
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 8'h9A || empty !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_data: pv=%b pd=%h empty=%b required 1 9a 1", pop_valid, pop_data, empty);
        end
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_empty_push_pop();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
